div: RTL and testbench
======================

# div

Iterative 32-bit radix-2 integer divider for the MIPS integer execute cluster, handling DIV and DIVU. It is the divide counterpart of the pipelined multiplier. It accepts one operation at a time through a ready/go handshake and runs a restoring shift-subtract loop for 32 cycles. It then writes the remainder/quotient pair to the HI/LO physical register file and reports completion to the ROB with the captured ROB and HI/LO pointers.

## Interface
- No parameters. Widths come from `LG_ROB_ENTRIES` and `LG_HILO_PRF_ENTRIES` in uop.vh.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- opcode  in  opcode_t  DIV (signed) or DIVU (unsigned). Any value other than DIVU is treated as signed.
- go  in  1  start request; accepted only when ready==1.
- src_A  in  32  dividend.
- src_B  in  32  divisor.
- rob_ptr_in  in  `LG_ROB_ENTRIES`  ROB tag, captured on accept.
- hilo_prf_ptr_in  in  `LG_HILO_PRF_ENTRIES`  HI/LO destination, captured on accept.
- ready  out  1  block is idle and can accept go.
- y  out  64  {remainder (HI), quotient (LO)}; valid when complete==1.
- complete  out  1  single-cycle completion pulse.
- rob_ptr_out  out  `LG_ROB_ENTRIES`  captured ROB tag.
- hilo_prf_ptr_val_out  out  1  HI/LO write enable; equals complete.
- hilo_prf_ptr_out  out  `LG_HILO_PRF_ENTRIES`  captured HI/LO pointer.

## Operation
- States: IDLE, ITER, FIXUP, DONE.
- IDLE
  - ready=1.
  - On go, capture: signed flag, sign of A, sign of B, |A| and |B| (two's-complement absolute value only when signed), raw src_A, a zero-divisor flag, and both pointers.
  - Load remainder=0, quotient=|A|, and count=31. Go to ITER.
- ITER
  - Each cycle: {rem,quo} shifted left 1 bit; trial = rem_shifted − |B| computed 33 bits wide.
  - If the trial is non-negative: rem=trial and the new quotient LSB is 1. Otherwise the shifted rem is kept and the LSB is 0.
  - After the count==0 iteration, go to FIXUP.
- FIXUP, signed operations:
  - Quotient is negated when sign A ≠ sign B.
  - Remainder is negated when sign A is 1.
- FIXUP, unsigned operations: no correction.
- FIXUP, zero divisor (overrides the rules above): quotient=0xFFFFFFFF, remainder=raw src_A, for both DIV and DIVU.
- FIXUP then registers y and the pointers, and goes to DONE.
- DONE
  - complete=1 and hilo_prf_ptr_val_out=1 for exactly one cycle.
  - ready=0. Go to IDLE.
- INT_MIN/−1 yields quotient 0x80000000 and remainder 0 with no special-casing.
- go when ready==0 is ignored. The issue logic must not assert it then, and complete is produced only for accepted operations.
- y, rob_ptr_out and hilo_prf_ptr_out hold their last values outside DONE.

## Timing
- go is accepted at posedge T while in IDLE.
- ITER occupies cycles T+1..T+32, FIXUP is T+33, and DONE (complete high) is T+34.
- Latency is 34 cycles from go to complete, with the next accept possible at T+35.
- ready is 0 from T+1 through T+34.
- Reset (reset==0 at any posedge, including mid-ITER):
  - state=IDLE.
  - complete=0, hilo_prf_ptr_val_out=0, y=0, rob_ptr_out=0, hilo_prf_ptr_out=0.
  - The in-flight operation is discarded without completion.
  - ready=0 while reset is held and 1 in the first cycle after release.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A zero divisor goes IDLE→FIXUP directly, skipping ITER.
  - complete occurs at T+2 with the zero-divisor result.
  - Nonzero divisors are unchanged at 34 cycles.
- `DIV_ZERO_FAST_EN` undefined: a zero divisor runs the full 32 iterations and completes at T+34 with an identical result.

## Test plan
- DIVU 100/7, rob 5, hilo 3
  - complete exactly at T+34.
  - y={0x00000002,0x0000000E}, rob_ptr_out=5, hilo_prf_ptr_out=3.
  - ready=0 during T+1..T+34 and 1 at T+35.
- DIV −7/2 → y={0xFFFFFFFF,0xFFFFFFFD}.
- DIV 7/−2 → y={0x00000001,0xFFFFFFFD}.
- DIVU 0xFFFFFFFF/2 → y={0x00000001,0x7FFFFFFF}.
- DIV 0x80000000/0xFFFFFFFF → y={0x00000000,0x80000000}.
- DIV 5/0 and DIVU 5/0
  - Both give y={0x00000005,0xFFFFFFFF}.
  - complete at T+34, or at T+2 with `DIV_ZERO_FAST_EN`.
- Busy and reset behaviour:
  - A second go at T+10 is ignored: one complete only, with the first operation's pointers.
  - reset=0 at T+10 gives no complete at all and ready=1 after release.
  - A new go right after release completes correctly 34 cycles later.
- Back-to-back operations with go asserted at every ready cycle:
  - Completes are spaced 35 cycles apart.
  - Each complete carries its own rob_ptr_out and hilo_prf_ptr_out.

Source files
------------

// File: rtl/div.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 32 shift-subtract steps, sign fixup, HI/LO writeback.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop and completes two cycles after accept.
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 6
`endif

package div_uop_pkg;
  typedef logic [5:0] opcode_t;
  localparam opcode_t OP_DIV  = 6'd26;
  localparam opcode_t OP_DIVU = 6'd27;
endpackage

module div
  import div_uop_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  opcode_t                         opcode,
  input  logic                            go,
  input  logic [31:0]                     src_A,
  input  logic [31:0]                     src_B,
  input  logic [`LG_ROB_ENTRIES-1:0]      rob_ptr_in,
  input  logic [`LG_HILO_PRF_ENTRIES-1:0] hilo_prf_ptr_in,
  output logic                            ready,
  output logic [63:0]                     y,
  output logic                            complete,
  output logic [`LG_ROB_ENTRIES-1:0]      rob_ptr_out,
  output logic                            hilo_prf_ptr_val_out,
  output logic [`LG_HILO_PRF_ENTRIES-1:0] hilo_prf_ptr_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic                            signed_q, signed_d;
  logic                            sign_a_q, sign_a_d;
  logic                            sign_b_q, sign_b_d;
  logic                            zero_q, zero_d;
  logic [31:0]                     abs_b_q, abs_b_d;
  logic [31:0]                     raw_a_q, raw_a_d;
  logic [31:0]                     rem_q, rem_d;
  logic [31:0]                     quo_q, quo_d;
  logic [4:0]                      cnt_q, cnt_d;
  logic [`LG_ROB_ENTRIES-1:0]      rob_q, rob_d;
  logic [`LG_HILO_PRF_ENTRIES-1:0] hilo_q, hilo_d;
  logic [63:0]                     y_q, y_d;
  logic [`LG_ROB_ENTRIES-1:0]      rob_out_q, rob_out_d;
  logic [`LG_HILO_PRF_ENTRIES-1:0] hilo_out_q, hilo_out_d;
  logic                            complete_q, complete_d;

  logic                            op_signed_s;
  logic [31:0]                     abs_a_s;
  logic [32:0]                     rem_sh_s;
  logic [32:0]                     trial_s;
  logic [31:0]                     quo_fix_s;
  logic [31:0]                     rem_fix_s;

  // Next-state, datapath and output-register computation
  always_comb begin
    state_d     = state_q;
    signed_d    = signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    zero_d      = zero_q;
    abs_b_d     = abs_b_q;
    raw_a_d     = raw_a_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    rob_d       = rob_q;
    hilo_d      = hilo_q;
    y_d         = y_q;
    rob_out_d   = rob_out_q;
    hilo_out_d  = hilo_out_q;
    complete_d  = 1'b0;

    op_signed_s = (opcode != OP_DIVU);
    abs_a_s     = (op_signed_s && src_A[31]) ? (32'd0 - src_A) : src_A;
    rem_sh_s    = {rem_q, quo_q[31]};
    trial_s     = rem_sh_s - {1'b0, abs_b_q};

    // Zero divisor overrides the sign corrections for both opcodes
    if (zero_q) begin
      quo_fix_s = 32'hFFFF_FFFF;
      rem_fix_s = raw_a_q;
    end else if (signed_q) begin
      quo_fix_s = (sign_a_q != sign_b_q) ? (32'd0 - quo_q) : quo_q;
      rem_fix_s = sign_a_q ? (32'd0 - rem_q) : rem_q;
    end else begin
      quo_fix_s = quo_q;
      rem_fix_s = rem_q;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          signed_d = op_signed_s;
          sign_a_d = op_signed_s & src_A[31];
          sign_b_d = op_signed_s & src_B[31];
          abs_b_d  = (op_signed_s && src_B[31]) ? (32'd0 - src_B) : src_B;
          raw_a_d  = src_A;
          zero_d   = (src_B == 32'd0);
          rob_d    = rob_ptr_in;
          hilo_d   = hilo_prf_ptr_in;
          rem_d    = 32'd0;
          quo_d    = abs_a_s;
          cnt_d    = 5'd31;
`ifdef DIV_ZERO_FAST_EN
          state_d  = (src_B == 32'd0) ? S_FIXUP : S_ITER;
`else
          state_d  = S_ITER;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (trial_s[32]) begin
          rem_d = rem_sh_s[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = trial_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIXUP;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIXUP: begin
        y_d        = {rem_fix_s, quo_fix_s};
        rob_out_d  = rob_q;
        hilo_out_d = hilo_q;
        complete_d = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      zero_q     <= 1'b0;
      abs_b_q    <= 32'd0;
      raw_a_q    <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      cnt_q      <= 5'd0;
      rob_q      <= '0;
      hilo_q     <= '0;
      y_q        <= 64'd0;
      rob_out_q  <= '0;
      hilo_out_q <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      signed_q   <= signed_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      zero_q     <= zero_d;
      abs_b_q    <= abs_b_d;
      raw_a_q    <= raw_a_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      rob_q      <= rob_d;
      hilo_q     <= hilo_d;
      y_q        <= y_d;
      rob_out_q  <= rob_out_d;
      hilo_out_q <= hilo_out_d;
      complete_q <= complete_d;
    end
  end

  // ready is masked while reset is held so no go is taken during reset
  assign ready                = reset & (state_q == S_IDLE);
  assign y                    = y_q;
  assign complete             = complete_q;
  assign hilo_prf_ptr_val_out = complete_q;
  assign rob_ptr_out          = rob_out_q;
  assign hilo_prf_ptr_out     = hilo_out_q;

endmodule

// File: tb/tb_div.sv
// Directed testbench for div: hand-computed quotient/remainder vectors, latency, busy and reset behaviour.
module tb_div;
  import div_uop_pkg::*;

  localparam int RW = `LG_ROB_ENTRIES;
  localparam int HW = `LG_HILO_PRF_ENTRIES;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  opcode_t       opcode = OP_DIVU;
  logic          go = 1'b0;
  logic [31:0]   src_A = 32'd0;
  logic [31:0]   src_B = 32'd0;
  logic [RW-1:0] rob_ptr_in = '0;
  logic [HW-1:0] hilo_prf_ptr_in = '0;
  logic          ready;
  logic [63:0]   y;
  logic          complete;
  logic [RW-1:0] rob_ptr_out;
  logic          hilo_prf_ptr_val_out;
  logic [HW-1:0] hilo_prf_ptr_out;

  int n_cmp = 0;
  int n_err = 0;

  div dut (
    .clk(clk), .reset(reset), .opcode(opcode), .go(go),
    .src_A(src_A), .src_B(src_B), .rob_ptr_in(rob_ptr_in),
    .hilo_prf_ptr_in(hilo_prf_ptr_in), .ready(ready), .y(y),
    .complete(complete), .rob_ptr_out(rob_ptr_out),
    .hilo_prf_ptr_val_out(hilo_prf_ptr_val_out), .hilo_prf_ptr_out(hilo_prf_ptr_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and check latency, busy ready, result, pointers and return to idle
  task automatic run_op(input string tag, input opcode_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [RW-1:0] rob, input logic [HW-1:0] hilo,
                        input logic [63:0] exp_y, input int exp_lat);
    int  k;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    opcode = op; src_A = a; src_B = b; rob_ptr_in = rob; hilo_prf_ptr_in = hilo; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    k = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (complete === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check_eq({tag, "_y"}, y, exp_y);
    check_eq({tag, "_rob"}, 64'(rob_ptr_out), 64'(rob));
    check_eq({tag, "_hilo"}, 64'(hilo_prf_ptr_out), 64'(hilo));
    check_eq({tag, "_wen"}, 64'(hilo_prf_ptr_val_out), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check_eq({tag, "_rdy_after"}, 64'(ready), 64'd1);
    check_eq({tag, "_pulse"}, 64'(complete), 64'd0);
    check_eq({tag, "_y_hold"}, y, exp_y);
  endtask

  logic [31:0]   b2b_a   [3] = '{32'd1000, 32'd1001, 32'd1002};
  logic [63:0]   b2b_y   [3] = '{{32'd1, 32'd333}, {32'd2, 32'd333}, {32'd0, 32'd334}};
  logic [RW-1:0] b2b_rob [3] = '{6'd11, 6'd12, 6'd13};
  logic [HW-1:0] b2b_hilo[3] = '{6'd21, 6'd22, 6'd23};

  initial begin
    int ncomp;
    int cyc;
    int n_acc;
    int n_done;
    int last_done;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_complete", 64'(complete), 64'd0);
    check_eq("rst_y", y, 64'd0);
    check_eq("rst_rob", 64'(rob_ptr_out), 64'd0);
    check_eq("rst_hilo", 64'(hilo_prf_ptr_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 64'(ready), 64'd1);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 6'd5, 6'd3, {32'h2, 32'hE}, 34);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd1, 6'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 6'd6, 6'd7, {32'h1, 32'hFFFF_FFFD}, 34);
    run_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 6'd8, 6'd9, {32'h1, 32'h7FFF_FFFF}, 34);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 6'd11, {32'h0, 32'h8000_0000}, 34);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 6'd12, 6'd13, {32'h5, 32'hFFFF_FFFF}, ZLAT);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 6'd14, 6'd15, {32'h5, 32'hFFFF_FFFF}, ZLAT);

    // Second go while busy must be ignored
    @(negedge clk);
    opcode = OP_DIVU; src_A = 32'd100; src_B = 32'd7; rob_ptr_in = 6'd9; hilo_prf_ptr_in = 6'd4; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    ncomp = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 10) begin
        src_A = 32'd50; src_B = 32'd5; rob_ptr_in = 6'd20; hilo_prf_ptr_in = 6'd21; go = 1'b1;
      end else begin
        go = 1'b0;
      end
      if (complete === 1'b1) begin
        ncomp++;
        check_eq("busy_rob", 64'(rob_ptr_out), 64'd9);
        check_eq("busy_hilo", 64'(hilo_prf_ptr_out), 64'd4);
        check_eq("busy_y", y, {32'h2, 32'hE});
      end
    end
    check_eq("busy_ncomp", 64'(ncomp), 64'd1);

    // Reset mid-iteration discards the operation
    @(negedge clk);
    opcode = OP_DIVU; src_A = 32'd77; src_B = 32'd3; rob_ptr_in = 6'd30; hilo_prf_ptr_in = 6'd31; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", 64'(ready), 64'd0);
    check_eq("mid_rst_y", y, 64'd0);
    check_eq("mid_rst_rob", 64'(rob_ptr_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ncomp = 0;
    @(negedge clk);
    check_eq("mid_rel_ready", 64'(ready), 64'd1);
    for (int k = 0; k < 30; k++) begin
      if (complete === 1'b1) ncomp++;
      @(negedge clk);
    end
    check_eq("mid_rst_nocomp", 64'(ncomp), 64'd0);
    run_op("after_rst", OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd17, 6'd18, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);

    // Back-to-back: go held high, operands refreshed on every ready cycle
    cyc = 0; n_acc = 0; n_done = 0; last_done = -1;
    while (n_done < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (complete === 1'b1) begin
        if (n_done > 0) check_eq("b2b_spacing", 64'(cyc - last_done), 64'd35);
        check_eq("b2b_y", y, b2b_y[n_done]);
        check_eq("b2b_rob", 64'(rob_ptr_out), 64'(b2b_rob[n_done]));
        check_eq("b2b_hilo", 64'(hilo_prf_ptr_out), 64'(b2b_hilo[n_done]));
        last_done = cyc;
        n_done++;
      end
      if (ready === 1'b1) begin
        if (n_acc < 3) begin
          opcode = OP_DIVU; src_A = b2b_a[n_acc]; src_B = 32'd3;
          rob_ptr_in = b2b_rob[n_acc]; hilo_prf_ptr_in = b2b_hilo[n_acc]; go = 1'b1;
          n_acc++;
        end else begin
          go = 1'b0;
        end
      end
    end
    go = 1'b0;
    check_eq("b2b_ndone", 64'(n_done), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
